// File: rtl/operand_skid_buf.sv
// Two-entry skid buffer between the operand select and the consuming PE.
// When OPERAND_SKID_XFER_CNT_EN is defined, an output-transfer counter is added.
module operand_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef OPERAND_SKID_XFER_CNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] main_reg, main_next;
  logic [WIDTH-1:0] skid_reg, skid_next;
  logic             in_fire, out_fire;

  // Handshake flags come only from registered state, so no in-to-out path exists.
  assign out_valid = (state_reg == BUSY) || (state_reg == FULL);
  assign in_ready  = (state_reg != FULL);
  assign out_data  = main_reg;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    unique case (state_reg)
      EMPTY: begin
        if (in_fire) begin
          main_next  = in_data;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_next = in_data;
        end else if (in_fire) begin
          skid_next  = in_data;
          state_next = FULL;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          main_next  = skid_reg;
          state_next = BUSY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

`ifdef OPERAND_SKID_XFER_CNT_EN
  logic [15:0] xfer_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_reg <= '0;
    end else if (out_fire) begin
      xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_reg;
`endif

endmodule

// File: tb/tb_operand_skid_buf.sv
// Directed bench for operand_skid_buf: vector table plus hand-written
// multi-cycle sequences for streaming, async reset and the optional counter.
module tb_operand_skid_buf;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
`ifdef OPERAND_SKID_XFER_CNT_EN
  logic [15:0]      xfer_cnt;
`endif

  int errors = 0;
  int checks = 0;

  operand_skid_buf #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef OPERAND_SKID_XFER_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        ov;
    logic        ir;
    logic        chk_d;
    logic [31:0] od;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Inputs applied, then state checked one edge later.
    vecs[0]  = '{1'b1, 32'd31,  1'b1, 1'b1, 1'b1, 1'b1, 32'd31};
    vecs[1]  = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 1'b0, 32'd0};
    vecs[2]  = '{1'b1, 32'd61,  1'b0, 1'b1, 1'b1, 1'b1, 32'd61};
    vecs[3]  = '{1'b1, 32'd187, 1'b0, 1'b1, 1'b0, 1'b1, 32'd61};
    vecs[4]  = '{1'b1, 32'd99,  1'b0, 1'b1, 1'b0, 1'b1, 32'd61};
    vecs[5]  = '{1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 1'b1, 32'd61};
    vecs[6]  = '{1'b0, 32'd0,   1'b1, 1'b1, 1'b1, 1'b1, 32'd187};
    vecs[7]  = '{1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 1'b0, 32'd0};
    vecs[8]  = '{1'b1, 32'd7,   1'b0, 1'b1, 1'b1, 1'b1, 32'd7};
    vecs[9]  = '{1'b1, 32'd8,   1'b1, 1'b1, 1'b1, 1'b1, 32'd8};
    vecs[10] = '{1'b1, 32'd11,  1'b0, 1'b1, 1'b0, 1'b1, 32'd8};
    vecs[11] = '{1'b0, 32'd0,   1'b1, 1'b1, 1'b1, 1'b1, 32'd11};

    #1 rst = 1'b1;
    #2;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset out_data",  out_data,           32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy);
      step();
      chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
      chk($sformatf("vec%0d in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].ir});
      if (vecs[i].chk_d)
        chk($sformatf("vec%0d out_data", i), out_data, vecs[i].od);
    end
    drive(1'b0, 32'd0, 1'b1);
    step();
    chk("drain out_valid", {31'd0, out_valid}, 32'd0);

    // Back-to-back stream of 100 operands with the consumer always ready.
    for (int i = 0; i < 100; i++) begin
      chk($sformatf("stream%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      drive(1'b1, 32'd127 + i, 1'b1);
      step();
      chk($sformatf("stream%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream%0d out_data", i),  out_data, 32'd127 + i);
    end
    drive(1'b0, 32'd0, 1'b1);
    step();
    chk("stream end out_valid", {31'd0, out_valid}, 32'd0);

    // Fill to FULL (5 in main, 6 in skid) then reset between clock edges.
    drive(1'b1, 32'd5, 1'b0);
    step();
    drive(1'b1, 32'd6, 1'b0);
    step();
    chk("full in_ready", {31'd0, in_ready}, 32'd0);
    chk("full out_data", out_data, 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("async rst in_ready",  {31'd0, in_ready},  32'd1);
    chk("async rst out_data",  out_data,           32'd0);
    drive(1'b1, 32'd77, 1'b1);
    step();
    chk("rst edge no accept", {31'd0, out_valid}, 32'd0);
    chk("rst edge out_data",  out_data,           32'd0);
    rst = 1'b0;
    drive(1'b1, 32'd9, 1'b0);
    step();
    chk("post rst out_valid", {31'd0, out_valid}, 32'd1);
    chk("post rst out_data",  out_data,           32'd9);
    chk("post rst in_ready",  {31'd0, in_ready},  32'd1);
    drive(1'b0, 32'd0, 1'b1);
    step();
    chk("skid discarded", {31'd0, out_valid}, 32'd0);

`ifdef OPERAND_SKID_XFER_CNT_EN
    begin
      int exp_cnt;
      int guard;
      rst = 1'b1;
      #2;
      chk("cnt reset", {16'd0, xfer_cnt}, 32'd0);
      step();
      rst = 1'b0;
      exp_cnt = 0;
      guard = 0;
      drive(1'b1, 32'd1, 1'b1);
      while (exp_cnt < 65535 && guard < 70000) begin
        if (out_valid && out_ready) exp_cnt++;
        step();
        guard++;
      end
      chk("cnt preload bound", {31'd0, (exp_cnt == 65535)}, 32'd1);
      chk("cnt at ffff", {16'd0, xfer_cnt}, 32'h0000FFFF);
      drive(1'b0, 32'd0, 1'b1);
      step();
      chk("cnt wrap", {16'd0, xfer_cnt}, 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
